// File: rtl/nibble_serial_adder.sv
// Wide add/subtract unit that reuses one 4-bit carry-select slice per clock,
// walking the operand nibbles LSB-first with a registered inter-nibble carry.

// 4-bit carry-select slice: low pair ripples, high pair is precomputed for both
// carry values and selected by the low-pair carry.
module carry_select_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  // Both high-pair candidates are formed in parallel with the low pair.
  always_comb begin
    lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
    hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    s[1:0] = lo[1:0];
    if (lo[2]) begin
      s[3:2] = hi1[1:0];
      co     = hi1[2];
    end else begin
      s[3:2] = hi0[1:0];
      co     = hi0[2];
    end
  end

endmodule

module nibble_serial_adder #(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned W       = 4 * NIBBLES
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Run,
  input  logic         Sub,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Sum,
  output logic         CO,
  output logic         OVF,
  output logic         Busy,
  output logic         Done
);

  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  sum_q;
  logic          co_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;

  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic [3:0]    slice_s;
  logic          slice_co;

  // Select the nibble pair addressed by the current index.
  always_comb begin
    slice_a = a_q[4*idx_q +: 4];
    slice_b = b_q[4*idx_q +: 4];
  end

  carry_select_adder4 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Run) begin
            a_q     <= A;
            // Subtraction is A + ~B + 1: invert here, inject the +1 as carry-in.
            b_q     <= Sub ? ~B : B;
            carry_q <= Sub;
            idx_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          sum_q[4*idx_q +: 4] <= slice_s;
          carry_q             <= slice_co;
          idx_q               <= idx_q + IW'(1);
          if (idx_q == IW'(NIBBLES - 1)) begin
            co_q    <= slice_co;
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (slice_s[3] != a_q[W-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Wait for Run to drop so a held button triggers only once.
          if (!Run) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Sum  = sum_q;
  assign CO   = co_q;
  assign OVF  = ovf_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide add/subtract unit that time-shares a single 4-bit carry-select adder slice (carry_select_adder4) across all nibbles of a 4·NIBBLES-bit operand. A small FSM captures operands on Run, walks the nibbles LSB-first while registering the inter-nibble carry, and presents a stable Sum, CO and OVF with Done. It sits between the switch/button front end and the hex-display path of the lab top level, replacing a wide ripple/select adder when area matters more than latency.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4·NIBBLES; legal range 2..8.
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  one clock; reset is asynchronous and active-low.
- Run  in  1  level start request; sampled only in IDLE.
- Sub  in  1  0 = A+B, 1 = A−B (two's complement); captured with operands.
- A  in  W  operand A; captured on start.
- B  in  W  operand B; captured on start.
- Sum  out  W  result register.
- CO  out  1  final carry out (for Sub: 1 = no borrow).
- OVF  out  1  signed overflow of final result.
- Busy  out  1  high in ADD state.
- Done  out  1  high in DONE state; results valid and stable.

## Operation
- States: IDLE, ADD, DONE. Reset (Reset_n=0, asynchronous) forces IDLE; Sum=0, CO=0, OVF=0, Busy=0, Done=0, nibble index=0, carry reg=0, operand regs=0.
- IDLE: if Run=1 at edge → capture A into Areg, (Sub ? ~B : B) into Breg, Sub into Subreg; carry reg ← Sub; index ← 0; Sum ← 0; CO, OVF ← 0; go ADD. Else stay.
- ADD: slice inputs = Areg[4i+3:4i], Breg[4i+3:4i], c_in = carry reg (i = index). Each edge: Sum[4i+3:4i] ← slice sum; carry reg ← slice CO; index ← index+1. On edge where index = NIBBLES−1: also CO ← slice CO, OVF ← (Areg[W−1] == Breg[W−1]) && (slice sum bit 3 != Areg[W−1]); go DONE.
- DONE: hold Sum/CO/OVF. If Run=0 at edge → IDLE (Sum/CO/OVF retained). If Run=1 → stay DONE; no retrigger until Run returns to 0 (button-hold safe).
- Run, Sub, A, B changes while in ADD or DONE are ignored; only captured values are used.
- Arithmetic is modulo 2^W; Sum never widens. Sub uses ~B with initial carry 1; no separate negation step.
- Exactly one slice instance; no other adder in the datapath.

## Timing
- Edge 0: Run=1 sampled in IDLE → Busy=1 after edge 0.
- Edges 1..NIBBLES: one nibble per edge; nibble i written at edge i+1.
- After edge NIBBLES: Busy=0, Done=1, Sum/CO/OVF final. Latency Run-sample → Done = NIBBLES+1 edges (5 for default).
- Intermediate Sum during ADD is partial (upper nibbles 0); consumers use Sum only when Done=1 or in IDLE after a completed op.
- Reset_n asserted mid-ADD/DONE: immediate return to reset values regardless of Clk; no partial result retained. Run high at reset release: start taken at first edge with Reset_n=1.
- Busy and Done never high simultaneously; exactly one of IDLE/ADD/DONE.

## Test plan
- NIBBLES=4, Sub=0, A=0x1234, B=0x4321, Run pulse → Done exactly 5 edges after Run sampled; Sum=0x5555, CO=0, OVF=0; Busy high 4 cycles.
- Sub=0, A=0xFFFF, B=0x0001 → Sum=0x0000, CO=1, OVF=0 (carry ripples through all four nibbles); 0x7FFF+0x0001 → Sum=0x8000, CO=0, OVF=1.
- Sub=1, A=0x8000, B=0x0001 → Sum=0x7FFF, CO=1, OVF=1; Sub=1, A=0x0003, B=0x0005 → Sum=0xFFFE, CO=0, OVF=0.
- Run held high 20 cycles with A=0x0001, B=0x0001 → one operation only, Sum=0x0002, Done stays 1 while Run=1; change A/B during ADD → result unaffected; drop Run → IDLE, Sum retained; raise Run again → new op.
- Start 0x1234+0x4321, assert Reset_n=0 between edges 2 and 3 → all outputs 0 immediately; release with Run=0 → stays IDLE; next Run with 0x0F0F+0x0101 → Sum=0x1010.
- NIBBLES=2 build: A=0xFF, B=0x01 → Done after 3 edges, Sum=0x00, CO=1, OVF=0.
